data_sram_master: RTL and testbench
===================================

DATA_SRAM_MASTER -- requirements
Module: data_sram_master

Interface
REQ-001 SHALL have parameter: TIMEOUT, 0, cycles allowed from request issue to data_data_ok (0 = watchdog disabled).
REQ-002 SHALL have ports (name direction width meaning):
 clk  in  1  sole clock, rising edge
 rst  in  1  reset, asynchronous, active-low
 mem_en  in  1  pipeline access request, held until mem_done, addr_err or bus_err
 mem_wr  in  1  1 = store, 0 = load
 mem_size  in  2  0 byte, 1 half, 2 word, 3 treated as word
 mem_signed  in  1  load sign-extend
 mem_addr  in  32  byte address
 mem_wdata  in  32  store data, right-aligned
 flush  in  1  cancel current pipeline access
 mem_rdata  out  32  aligned, extended load result
 mem_done  out  1  access complete this cycle
 mem_stall  out  1  pipeline must hold
 addr_err  out  1  misaligned access pulse
 bus_err  out  1  watchdog expiry pulse
 data_req  out  1  sram-like request
 data_wr  out  1  sram-like write
 data_size  out  2  sram-like size
 data_addr  out  32  sram-like address
 data_wdata  out  32  sram-like write data
 data_rdata  in  32  sram-like read data
 data_addr_ok  in  1  request accepted
 data_data_ok  in  1  data returned / write done

Function
REQ-003 SHALL implement FSM IDLE, ADDR, DATA, DRAIN; at most one outstanding transaction.
REQ-004 IDLE: mem_en=1, flush=0, no addr_err -> latch wr/size/signed/addr/wdata, go ADDR; data_req asserted from next cycle.
REQ-005 ADDR: data_req=1, data_wr/size/addr/wdata stable from latches until data_addr_ok; data_addr_ok=1 -> DATA, data_req=0 next cycle.
REQ-006 DATA: data_data_ok=1 -> mem_done=1 same cycle (combinational), mem_rdata valid same cycle, go IDLE.
REQ-007 data_addr_ok and data_data_ok both high in ADDR SHALL complete as in REQ-006, go IDLE.
REQ-008 data_data_ok outside ADDR/DATA/DRAIN SHALL be ignored.
REQ-009 mem_stall = (mem_en and not mem_done and not addr_err and not bus_err) or state==DRAIN.
REQ-010 Store data: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word unchanged; data_addr = latched mem_addr.
REQ-011 Load data: data_rdata shifted right by 8*addr[1:0]; byte/half zero- or sign-extended per mem_signed; word unchanged.
REQ-012 flush in IDLE, or in ADDR without data_addr_ok: abandon, go IDLE, data_req=0 next cycle, no mem_done.
REQ-013 flush in ADDR with data_addr_ok, or in DATA without data_data_ok: go DRAIN; DRAIN waits data_data_ok, then IDLE; mem_done never asserted for drained access.
REQ-014 flush coincident with completion: mem_done suppressed, go IDLE.
REQ-015 TIMEOUT>0: counter cleared on IDLE->ADDR, increments each cycle in ADDR/DATA/DRAIN; reaching TIMEOUT -> bus_err=1 one cycle, data_req=0, go IDLE.
REQ-016 mem_done, addr_err, bus_err SHALL be mutually exclusive; each only while mem_en=1 (bus_err excepted in DRAIN).

Reset
REQ-017 rst=0 SHALL asynchronously force IDLE; data_req, data_wr, data_size, data_addr, data_wdata, latches, counter = 0; mem_done, addr_err, bus_err, mem_stall = 0; mem_rdata = 0.
REQ-018 Reset mid-ADDR/DATA SHALL drop data_req immediately; a late data_data_ok after release is ignored per REQ-008.

Configuration
REQ-019 Macro DATA_SRAM_MASTER_ADDR_CHECK_EN defined: in IDLE with mem_en, half with addr[0]=1 or word with addr[1:0]!=0 -> addr_err=1 same cycle, no request issued, stay IDLE.
REQ-020 Macro undefined: addr_err tied 0; misaligned accesses issued unchanged.

Verification
REQ-021 Word load addr 0x100, addr_ok at cycle 2, data_ok cycle 4 rdata 0x12345678 -> mem_done cycle 4, mem_rdata 0x12345678, one data_req acceptance.
REQ-022 Signed byte load addr 0x103, rdata 0x80FFFFFF -> mem_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-023 Half store addr 0x202 wdata 0xAAAABEEF -> data_size 1, data_wdata 0xBEEFBEEF, data_addr 0x202.
REQ-024 flush one cycle after addr_ok, data_ok 3 cycles later -> no mem_done, mem_stall=1 until data_ok, next access issued after.
REQ-025 TIMEOUT=8, responder never asserts data_ok -> bus_err pulse 8 cycles after issue, data_req=0, FSM IDLE.
REQ-026 With DATA_SRAM_MASTER_ADDR_CHECK_EN, word load addr 0x101 -> addr_err=1, data_req never asserted; without macro -> request issued with data_addr 0x101.

Source files
------------

// File: rtl/data_sram_master.sv
// Pipeline-to-SRAM-like data bus master: one outstanding access.
// Optional misalignment trap: DATA_SRAM_MASTER_ADDR_CHECK_EN.
module data_sram_master #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  typedef enum logic [1:0] {
    IDLE, ADDR, DATA, DRAIN
  } state_t;

  localparam logic [31:0] TMO_LAST =
    (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cnt_q, cnt_d;

  logic        misalign;
  logic        tmo;
  logic        done, aerr, berr;
  logic [31:0] shifted;
  logic [31:0] ld_data;

`ifdef DATA_SRAM_MASTER_ADDR_CHECK_EN
  assign misalign = (mem_size == 2'd1 && mem_addr[0]) ||
                    (mem_size[1] && mem_addr[1:0] != 2'd0);
`else
  assign misalign = 1'b0;
`endif

  assign tmo = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  // Next-state, capture of the access and completion strobes.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    aerr    = 1'b0;
    berr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_en && !flush) begin
          if (misalign) begin
            aerr = 1'b1;
          end else begin
            state_d = ADDR;
            wr_d    = mem_wr;
            size_d  = (mem_size == 2'd3) ? 2'd2 : mem_size;
            sgn_d   = mem_signed;
            addr_d  = mem_addr;
            cnt_d   = '0;
            unique case (mem_size)
              2'd0:    wdata_d = {4{mem_wdata[7:0]}};
              2'd1:    wdata_d = {2{mem_wdata[15:0]}};
              default: wdata_d = mem_wdata;
            endcase
          end
        end
      end
      ADDR: begin
        cnt_d = cnt_q + 32'd1;
        if (data_addr_ok && data_data_ok) begin
          state_d = IDLE;
          done    = mem_en && !flush;
        end else if (tmo) begin
          state_d = IDLE;
          berr    = mem_en && !flush;
        end else if (flush) begin
          state_d = data_addr_ok ? DRAIN : IDLE;
        end else if (data_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 32'd1;
        if (data_data_ok) begin
          state_d = IDLE;
          done    = mem_en && !flush;
        end else if (tmo) begin
          state_d = IDLE;
          berr    = mem_en && !flush;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 32'd1;
        if (data_data_ok) begin
          state_d = IDLE;
        end else if (tmo) begin
          state_d = IDLE;
          berr    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, access latches and watchdog counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shifted = data_rdata >> {addr_q[1:0], 3'b000};

  // Lane-select and extend the returned load data.
  always_comb begin
    ld_data = data_rdata;
    unique case (size_q)
      2'd0:    ld_data = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_data = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
      default: ld_data = data_rdata;
    endcase
  end

  assign mem_done   = done;
  assign bus_err    = berr;
  assign addr_err   = aerr & rst;
  assign mem_rdata  = done ? ld_data : 32'd0;
  assign mem_stall  = rst & ((mem_en & ~done & ~addr_err & ~berr) |
                             (state_q == DRAIN));
  assign data_req   = (state_q == ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_data_sram_master.sv
// Scoreboard bench for data_sram_master (TIMEOUT=8).
// Completions are queued by stimulus and checked by a monitor.
module tb_data_sram_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_wr = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic        mem_signed = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        flush = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_done, mem_stall, addr_err, bus_err;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [31:0] data_rdata = '0;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;

  int checks = 0;
  int failures = 0;
  int acc = 0;

  typedef struct {
    int          kind;
    logic [31:0] rd;
    bit          chk_rd;
  } exp_t;
  exp_t q[$];

  data_sram_master #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .flush(flush), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_stall(mem_stall),
    .addr_err(addr_err), .bus_err(bus_err),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a,
                              logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  function automatic void push(int kind, logic [31:0] rd,
                               bit c);
    exp_t e;
    e.kind = kind;
    e.rd = rd;
    e.chk_rd = c;
    q.push_back(e);
  endfunction

  always @(posedge clk)
    if (data_req && data_addr_ok) acc++;

  // Monitor: every completion strobe consumes one expectation.
  always @(negedge clk) begin
    int k;
    exp_t e;
    if (mem_done || bus_err || addr_err) begin
      k = mem_done ? 0 : (bus_err ? 1 : 2);
      chk("excl", 32'($countones({mem_done, bus_err, addr_err})), 1);
      if (q.size() == 0) begin
        chk("unexpected_event", 32'(k), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(k), 32'(e.kind));
        if (e.chk_rd && k == 0) chk("mem_rdata", mem_rdata, e.rd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic wr, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] a,
                        input logic [31:0] wd, input int alat,
                        input int dlat, input logic [31:0] rd,
                        input logic [31:0] exp_rd,
                        input logic [31:0] exp_wd,
                        input logic [1:0] exp_sz);
    mem_en = 1'b1;
    mem_wr = wr;
    mem_size = sz;
    mem_signed = sgn;
    mem_addr = a;
    mem_wdata = wd;
    step();
    chk("data_req", 32'(data_req), 1);
    chk("mem_stall", 32'(mem_stall), 1);
    chk("data_addr", data_addr, a);
    chk("data_size", 32'(data_size), 32'(exp_sz));
    chk("data_wr", 32'(data_wr), 32'(wr));
    chk("data_wdata", data_wdata, exp_wd);
    repeat (alat) step();
    data_addr_ok = 1'b1;
    if (dlat == 0) begin
      push(0, exp_rd, !wr);
      data_data_ok = 1'b1;
      data_rdata = rd;
    end
    step();
    data_addr_ok = 1'b0;
    if (dlat > 0) begin
      repeat (dlat - 1) step();
      push(0, exp_rd, !wr);
      data_data_ok = 1'b1;
      data_rdata = rd;
      step();
    end
    data_data_ok = 1'b0;
    mem_en = 1'b0;
    chk("idle_req", 32'(data_req), 0);
  endtask

  initial begin
    int a0;
    int seen;
    // Reset with hostile inputs.
    mem_en = 1'b1;
    mem_size = 2'd2;
    mem_addr = 32'h101;
    data_rdata = 32'hFFFF_FFFF;
    data_data_ok = 1'b1;
    #12;
    chk("rst_req", 32'(data_req), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_done", 32'(mem_done), 0);
    chk("rst_aerr", 32'(addr_err), 0);
    chk("rst_berr", 32'(bus_err), 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_size", 32'(data_size), 0);
    mem_en = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = '0;
    step();
    rst = 1'b1;
    step();

    a0 = acc;
    access(0, 2, 0, 32'h100, 0, 1, 2, 32'h1234_5678,
           32'h1234_5678, 0, 2);
    chk("one_accept", 32'(acc - a0), 1);
    access(0, 0, 1, 32'h103, 0, 0, 1, 32'h80FF_FFFF,
           32'hFFFF_FF80, 0, 0);
    access(0, 0, 0, 32'h103, 0, 0, 1, 32'h80FF_FFFF,
           32'h0000_0080, 0, 0);
    access(1, 1, 0, 32'h202, 32'hAAAA_BEEF, 2, 1, 0,
           0, 32'hBEEF_BEEF, 1);
    access(1, 0, 0, 32'h41, 32'h1234_56AB, 0, 0, 0,
           0, 32'hABAB_ABAB, 0);
    access(0, 1, 1, 32'h102, 0, 0, 0, 32'hF00D_1234,
           32'hFFFF_F00D, 0, 1);
    access(0, 1, 0, 32'h2, 0, 1, 1, 32'h8765_1111,
           32'h0000_8765, 0, 1);
    access(0, 3, 0, 32'h10C, 0, 0, 2, 32'hCAFE_F00D,
           32'hCAFE_F00D, 0, 2);
    access(0, 0, 1, 32'h101, 0, 0, 1, 32'h0000_7F00,
           32'h0000_007F, 0, 0);

    // Flush after address phase: drain, no completion.
    mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'd2;
    mem_addr = 32'h300;
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    mem_en = 1'b0;
    chk("drain_stall1", 32'(mem_stall), 1);
    chk("drain_req", 32'(data_req), 0);
    step();
    chk("drain_stall2", 32'(mem_stall), 1);
    step();
    data_data_ok = 1'b1;
    data_rdata = 32'h5555_5555;
    #1;
    chk("drain_stall3", 32'(mem_stall), 1);
    step();
    data_data_ok = 1'b0;
    chk("post_drain_stall", 32'(mem_stall), 0);
    access(0, 2, 0, 32'h304, 0, 0, 1, 32'h0BAD_F00D,
           32'h0BAD_F00D, 0, 2);

    // Flush in address phase without acceptance: abandon.
    mem_en = 1'b1; mem_addr = 32'h400;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    mem_en = 1'b0;
    chk("abandon_req", 32'(data_req), 0);
    step();

    // Flush coincident with completion: suppressed.
    mem_en = 1'b1; mem_addr = 32'h404;
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    flush = 1'b1;
    step();
    data_data_ok = 1'b0;
    flush = 1'b0;
    mem_en = 1'b0;
    chk("flushdone_req", 32'(data_req), 0);
    step();

    // Watchdog expiry with no data response.
    push(1, 0, 0);
    mem_en = 1'b1; mem_addr = 32'h500;
    step();
    seen = 0;
    for (int i = 1; i <= 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus_err) seen = i;
      if (i == 1) data_addr_ok = 1'b1;
      else data_addr_ok = 1'b0;
      step();
    end
    data_addr_ok = 1'b0;
    mem_en = 1'b0;
    chk("bus_err_cycle", 32'(seen), 8);
    chk("tmo_req", 32'(data_req), 0);
    step();

    // Misaligned word load.
`ifdef DATA_SRAM_MASTER_ADDR_CHECK_EN
    push(2, 0, 0);
    mem_en = 1'b1; mem_size = 2'd2; mem_addr = 32'h101;
    step();
    chk("mis_req", 32'(data_req), 0);
    mem_en = 1'b0;
    step();
`else
    access(0, 2, 0, 32'h101, 0, 1, 1, 32'h1122_3344,
           32'h1122_3344, 0, 2);
`endif

    // Reset during data phase, then a stray data_ok.
    mem_en = 1'b1; mem_addr = 32'h600;
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_req", 32'(data_req), 0);
    chk("rst_mid_stall", 32'(mem_stall), 0);
    mem_en = 1'b0;
    step();
    rst = 1'b1;
    data_data_ok = 1'b1;
    step();
    data_data_ok = 1'b0;
    chk("stray_req", 32'(data_req), 0);
    step();
    step();

    chk("sb_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
